accum_mem_arbiter: RTL

Shares the single TinyRV1 data-memory port between the processor data port (requester P) and the accumulator accelerator (requester X).
- Round-robin arbitration on the request side.
- An in-order ID FIFO tracks which requester owns each outstanding request.
- Each memory response is routed back to its owner.
- Sits between the processor/accumulator datapaths and the memory model. The accelerator FSM drives its X request side unchanged.

---
 rtl/accum_mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/accum_mem_arbiter.sv
// Round-robin arbiter sharing one in-order data-memory port between processor (P) and accumulator (X).
// Optional ACCUM_ARB_LOCK_EN adds x_lock, which forces X to win while asserted.
module accum_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req_val,
  input  logic [ADDR_W-1:0] p_req_addr,
  output logic              p_req_rdy,
  output logic              p_resp_val,
  output logic [DATA_W-1:0] p_resp_data,
  input  logic              x_req_val,
  input  logic [ADDR_W-1:0] x_req_addr,
  output logic              x_req_rdy,
  output logic              x_resp_val,
  output logic [DATA_W-1:0] x_resp_data,
`ifdef ACCUM_ARB_LOCK_EN
  input  logic              x_lock,
`endif
  output logic              m_req_val,
  output logic [ADDR_W-1:0] m_req_addr,
  input  logic              m_req_rdy,
  input  logic              m_resp_val,
  input  logic [DATA_W-1:0] m_resp_data,
  output logic              err
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);
  localparam logic ID_P = 1'b0;
  localparam logic ID_X = 1'b1;

  logic [MAX_OUTST-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 last_grant_q, last_grant_d;
  logic                 err_q, err_d;

  logic win_x_s;
  logic any_val_s;
  logic full_s;
  logic nonempty_s;
  logic fire_s;
  logic pop_s;
  logic head_s;

  // Winner selection: alternate on contention, otherwise the lone requester wins.
  always_comb begin
    win_x_s   = 1'b0;
    any_val_s = p_req_val | x_req_val;
`ifdef ACCUM_ARB_LOCK_EN
    if (x_lock) begin
      win_x_s   = 1'b1;
      any_val_s = x_req_val;
    end else if (p_req_val && x_req_val) begin
      win_x_s = (last_grant_q == ID_P);
    end else begin
      win_x_s = x_req_val;
    end
`else
    if (p_req_val && x_req_val) begin
      win_x_s = (last_grant_q == ID_P);
    end else begin
      win_x_s = x_req_val;
    end
`endif
  end

  // Handshakes and response routing; every output is forced low while reset is held.
  always_comb begin
    full_s      = (count_q == FULL_CNT);
    nonempty_s  = (count_q != {CNT_W{1'b0}});
    fire_s      = any_val_s & ~full_s & m_req_rdy;
    pop_s       = m_resp_val & nonempty_s;
    head_s      = fifo_q[rd_ptr_q];
    m_req_val   = rst & any_val_s & ~full_s;
    m_req_addr  = win_x_s ? x_req_addr : p_req_addr;
    p_req_rdy   = rst & m_req_rdy & ~full_s & ~win_x_s;
    x_req_rdy   = rst & m_req_rdy & ~full_s & win_x_s;
    p_resp_val  = rst & pop_s & (head_s == ID_P);
    x_resp_val  = rst & pop_s & (head_s == ID_X);
    p_resp_data = m_resp_data;
    x_resp_data = m_resp_data;
    err         = err_q;
  end

  // Next-state: the owner FIFO is pushed on a fired request and popped on a matched response.
  always_comb begin
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    err_d        = err_q | (m_resp_val & ~nonempty_s);
    if (fire_s) begin
      fifo_d[wr_ptr_q] = win_x_s;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      last_grant_d     = win_x_s;
    end else begin
      last_grant_d = last_grant_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({fire_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; last_grant resets to X so P wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q       <= {MAX_OUTST{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= {CNT_W{1'b0}};
      last_grant_q <= ID_X;
      err_q        <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule
